sprite_line_fetch: RTL and testbench

- Consumer side of the line-preparation interface: takes the 32-slot sprite list produced for a scanline (BufferArray + line_prepeared) and walks it slot by slot.
- For each valid slot, re-reads the object's attribute word from OAM and emits one per-sprite record to the line-buffer writer over a valid/ready handshake.
- Sits between the line-preparation stage and the sprite pixel renderer. It snapshots the list on start, so the preparer can immediately begin the next line.

---
 rtl/sprite_line_fetch.sv | 162 ++++++++++++++++
 tb/tb_sprite_line_fetch.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_line_fetch.sv
// Walks a snapshotted per-scanline sprite slot list, re-reads each valid object's OAM
// attribute word and hands one record per enabled sprite to the line-buffer writer.
module sprite_line_fetch #(
  parameter int maxObjectPerLine = 32,
  parameter int OAMMaxObjects    = 256,
  parameter int SpriteHeight     = 16,
  localparam int SLOT_W = $clog2(maxObjectPerLine),
  localparam int ADDR_W = $clog2(OAMMaxObjects),
  localparam int ROW_W  = $clog2(SpriteHeight)
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [maxObjectPerLine-1:0][ADDR_W:0] BufferArray,
  input  logic                                  line_prepeared,
  input  logic [9:0]                            sy,
  output logic [ADDR_W-1:0]                     oam_addr,
  input  logic [31:0]                           oam_data,
  output logic                                  spr_valid,
  input  logic                                  spr_ready,
  output logic [9:0]                            spr_x,
  output logic [ROW_W-1:0]                      spr_row,
  output logic [7:0]                            spr_tile,
  output logic [2:0]                            spr_palette,
  output logic [SLOT_W-1:0]                     spr_slot,
  output logic                                  busy,
  output logic                                  line_done,
  output logic                                  overrun
);

  typedef enum logic [2:0] {IDLE, SCAN, WAIT, EMIT, DONE} state_t;

  state_t                                state_q, state_d;
  logic                                  lp_q;
  logic [maxObjectPerLine-1:0][ADDR_W:0] list_q;
  logic [9:0]                            sy_q;
  logic [SLOT_W-1:0]                     ptr_q, ptr_d;
  logic [ADDR_W-1:0]                     addr_q, addr_d;
  logic                                  busy_q, overrun_q, vld_q;
  logic [9:0]                            x_q;
  logic [ROW_W-1:0]                      row_q;
  logic [7:0]                            tile_q;
  logic [2:0]                            pal_q;
  logic [SLOT_W-1:0]                     slot_q;

  logic              start, accept, capture, last_slot;
  logic [ADDR_W:0]   cur_slot;

  // Row inside the sprite: modular line distance, only the low bits are meaningful.
  function automatic logic [ROW_W-1:0] sprite_row(input logic [9:0] line, input logic [9:0] top);
    return ROW_W'(line - top);
  endfunction

  assign start     = line_prepeared && !lp_q;
  assign accept    = start && (state_q == IDLE || state_q == DONE);
  assign cur_slot  = list_q[ptr_q];
  assign last_slot = (ptr_q == SLOT_W'(maxObjectPerLine - 1));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    capture = 1'b0;
    case (state_q)
      SCAN: begin
        // Address goes out during SCAN so the word is on oam_data throughout WAIT.
        if (cur_slot[0]) begin
          addr_d  = cur_slot[ADDR_W:1];
          state_d = WAIT;
        end else if (last_slot) begin
          state_d = DONE;
        end else begin
          ptr_d = ptr_q + SLOT_W'(1);
        end
      end
      WAIT: begin
        if (oam_data[31]) begin
          capture = 1'b1;
          state_d = EMIT;
        end else if (last_slot) begin
          state_d = DONE;
        end else begin
          ptr_d   = ptr_q + SLOT_W'(1);
          state_d = SCAN;
        end
      end
      EMIT: begin
        if (spr_ready) begin
          if (last_slot) begin
            state_d = DONE;
          end else begin
            ptr_d   = ptr_q + SLOT_W'(1);
            state_d = SCAN;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (accept) begin
      state_d = SCAN;
      ptr_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      lp_q      <= 1'b0;
      ptr_q     <= '0;
      addr_q    <= '0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      vld_q     <= 1'b0;
      x_q       <= '0;
      row_q     <= '0;
      tile_q    <= '0;
      pal_q     <= '0;
      slot_q    <= '0;
    end else begin
      state_q <= state_d;
      lp_q    <= line_prepeared;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      if (accept)
        busy_q <= 1'b1;
      else if (state_q == DONE)
        busy_q <= 1'b0;
      if (start && !accept)
        overrun_q <= 1'b1;
      if (capture) begin
        vld_q  <= 1'b1;
        x_q    <= oam_data[30:21];
        row_q  <= sprite_row(sy_q, oam_data[20:11]);
        tile_q <= oam_data[10:3];
        pal_q  <= oam_data[2:0];
        slot_q <= ptr_q;
      end else if (state_q == EMIT && spr_ready) begin
        vld_q <= 1'b0;
      end
    end
  end

  // Snapshot of the prepared list, so the preparer is free to build the next line.
  always_ff @(posedge clk) begin
    if (accept) begin
      list_q <= BufferArray;
      sy_q   <= sy;
    end
  end

  assign oam_addr    = addr_d;
  assign spr_valid   = vld_q;
  assign spr_x       = x_q;
  assign spr_row     = row_q;
  assign spr_tile    = tile_q;
  assign spr_palette = pal_q;
  assign spr_slot    = slot_q;
  assign busy        = busy_q;
  assign line_done   = (state_q == DONE);
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_sprite_line_fetch.sv
// Bench for sprite_line_fetch: random slot lists and OAM contents checked against a
// slot-cost / record-list model derived from the list-walk rules.
`timescale 1ns/1ps
module tb_sprite_line_fetch;
  localparam int N = 32;

  typedef struct packed {
    logic [4:0] slot;
    logic [9:0] x;
    logic [3:0] row;
    logic [7:0] tile;
    logic [2:0] pal;
  } rec_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0][8:0] BufferArray;
  logic             line_prepeared;
  logic [9:0]       sy;
  logic [7:0]       oam_addr;
  logic [31:0]      oam_data;
  logic             spr_valid, spr_ready;
  logic [9:0]       spr_x;
  logic [3:0]       spr_row;
  logic [7:0]       spr_tile;
  logic [2:0]       spr_palette;
  logic [4:0]       spr_slot;
  logic             busy, line_done, overrun;

  always #5 clk = ~clk;

  sprite_line_fetch dut (
    .clk(clk), .reset(reset), .BufferArray(BufferArray), .line_prepeared(line_prepeared),
    .sy(sy), .oam_addr(oam_addr), .oam_data(oam_data), .spr_valid(spr_valid),
    .spr_ready(spr_ready), .spr_x(spr_x), .spr_row(spr_row), .spr_tile(spr_tile),
    .spr_palette(spr_palette), .spr_slot(spr_slot), .busy(busy), .line_done(line_done),
    .overrun(overrun)
  );

  // OAM with one cycle of read latency
  logic [31:0] oam_mem [256];
  always @(posedge clk) oam_data <= oam_mem[oam_addr];

  int checks = 0;
  int errors = 0;
  logic [N-1:0][8:0] list_m;
  logic [9:0]        sy_m;
  rec_t              exp_q[$];
  int                exp_cycles;
  int                exp_n;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: invalid slot costs 1 cycle, disabled object 2, emitted record 3 + stall.
  function automatic void build_model(input int stall);
    exp_q.delete();
    exp_cycles = 0;
    for (int i = 0; i < N; i++) begin
      logic [8:0]  s;
      logic [31:0] w;
      rec_t        r;
      int          d;
      s = list_m[i];
      if (!s[0]) begin
        exp_cycles += 1;
        continue;
      end
      w = oam_mem[s[8:1]];
      if (!w[31]) begin
        exp_cycles += 2;
        continue;
      end
      d = ((int'(sy_m) - int'(w[20:11])) % 16 + 16) % 16;
      r.slot = 5'(i);
      r.x    = w[30:21];
      r.row  = 4'(d);
      r.tile = w[10:3];
      r.pal  = w[2:0];
      exp_q.push_back(r);
      exp_cycles += 3 + stall;
    end
    exp_n = exp_q.size();
  endfunction

  function automatic logic [31:0] make_obj(input logic en, input logic [9:0] line);
    logic [9:0] y;
    y = line - 10'($urandom_range(0, 15));
    return {en, 10'($urandom), y, 8'($urandom), 3'($urandom)};
  endfunction

  task automatic make_random(input int pct_valid, input logic [9:0] line,
                             output logic [N-1:0][8:0] lst);
    for (int i = 0; i < N; i++) begin
      logic [7:0] idx;
      idx    = 8'($urandom);
      lst[i] = {idx, 1'($urandom_range(0, 99) < pct_valid)};
      oam_mem[idx] = make_obj(1'($urandom_range(0, 3) != 0), line);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one start edge, then scrambles the inputs to prove the list was snapshotted.
  task automatic start_pass(input logic [N-1:0][8:0] lst, input logic [9:0] line);
    BufferArray    = lst;
    sy             = line;
    list_m         = lst;
    sy_m           = line;
    line_prepeared = 1'b1;
    step();
    line_prepeared = 1'b0;
    for (int i = 0; i < N; i++) BufferArray[i] = 9'($urandom);
    sy = 10'($urandom);
  endtask

  task automatic run_pass(input string tag, input int stall, input bit rnd_ready, input int pulse_at);
    int   done_cyc;
    int   got;
    int   busy_bad;
    int   stall_cnt;
    bit   stalled;
    rec_t cur, prev, e;
    done_cyc  = -1;
    got       = 0;
    busy_bad  = 0;
    stall_cnt = 0;
    stalled   = 1'b0;
    prev      = '0;
    build_model(rnd_ready ? 0 : stall);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (line_done === 1'b1) begin
        done_cyc = cyc;
        break;
      end
      if (busy !== 1'b1) busy_bad++;
      line_prepeared = (pulse_at != 0 && cyc == pulse_at);
      if (spr_valid === 1'b1) begin
        cur = {spr_slot, spr_x, spr_row, spr_tile, spr_palette};
        if (stalled) check({tag, " hold"}, 64'(cur), 64'(prev));
        if (rnd_ready) spr_ready = 1'($urandom_range(0, 1));
        else           spr_ready = (stall_cnt >= stall);
        if (spr_ready) begin
          if (exp_q.size() != 0) e = exp_q.pop_front();
          else                   e = '1;
          check({tag, " record"}, 64'(cur), 64'(e));
          got++;
          stall_cnt = 0;
          stalled   = 1'b0;
        end else begin
          stall_cnt++;
          stalled = 1'b1;
          prev    = cur;
        end
      end else begin
        stalled   = 1'b0;
        spr_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      step();
    end
    spr_ready      = 1'b0;
    line_prepeared = 1'b0;
    check({tag, " done seen"}, 64'(done_cyc >= 0), 64'(1));
    if (!rnd_ready) check({tag, " done cycle"}, 64'(done_cyc), 64'(exp_cycles));
    check({tag, " count"}, 64'(got), 64'(exp_n));
    check({tag, " busy"}, 64'(busy_bad), 64'(0));
    step();
    check({tag, " pulse"}, 64'(line_done), 64'(0));
    check({tag, " idle"}, 64'(busy), 64'(0));
  endtask

  initial begin
    logic [N-1:0][8:0] lst;
    logic [N-1:0][8:0] full;
    logic [9:0]        line;
    int                found;
    int                quiet_bad;

    reset          = 1'b1;
    line_prepeared = 1'b0;
    spr_ready      = 1'b0;
    BufferArray    = '0;
    sy             = '0;
    for (int i = 0; i < 256; i++) oam_mem[i] = 32'($urandom);
    step(); step(); step();
    check("rst spr_valid", 64'(spr_valid), 64'(0));
    check("rst busy", 64'(busy), 64'(0));
    check("rst line_done", 64'(line_done), 64'(0));
    check("rst overrun", 64'(overrun), 64'(0));
    check("rst oam_addr", 64'(oam_addr), 64'(0));
    check("rst record", 64'({spr_slot, spr_x, spr_row, spr_tile, spr_palette}), 64'(0));
    reset = 1'b0;
    step(); step();

    // Empty list
    start_pass('0, 10'd100);
    run_pass("empty", 0, 1'b0, 0);
    check("empty overrun", 64'(overrun), 64'(0));

    // Full list, every sprite enabled, row = slot % 16
    for (int i = 0; i < N; i++) begin
      full[i]    = {8'(i), 1'b1};
      oam_mem[i] = {1'b1, 10'(i * 8), 10'(300 - i % 16), 8'(i), 3'(i % 8)};
    end
    start_pass(full, 10'd300);
    run_pass("full", 0, 1'b0, 0);
    step();

    // Backpressure: three enabled sprites, each stalled five cycles
    lst  = '0;
    line = 10'($urandom);
    lst[$urandom_range(0, 9)]   = {8'd100, 1'b1};
    lst[$urandom_range(10, 20)] = {8'd101, 1'b1};
    lst[$urandom_range(21, 31)] = {8'd102, 1'b1};
    for (int i = 100; i < 103; i++) oam_mem[i] = make_obj(1'b1, line);
    start_pass(lst, line);
    run_pass("stall", 5, 1'b0, 0);
    step();

    // Object disabled between preparation and fetch
    lst  = '0;
    line = 10'd517;
    for (int i = 0; i < 4; i++) begin
      lst[i]          = {8'(40 + i), 1'b1};
      oam_mem[40 + i] = make_obj(i != 2, line);
    end
    start_pass(lst, line);
    run_pass("disabled", 0, 1'b0, 0);
    step();

    // Randomized lists, random and fixed-stall downstream
    for (int p = 0; p < 4; p++) begin
      line = 10'($urandom);
      make_random(50, line, lst);
      start_pass(lst, line);
      run_pass("rand_ready", 0, 1'b1, 0);
      step();
    end
    for (int p = 0; p < 2; p++) begin
      line = 10'($urandom);
      make_random(70, line, lst);
      start_pass(lst, line);
      run_pass("rand_stall", $urandom_range(0, 3), 1'b0, 0);
      step();
    end

    // Second start edge during a pass
    line = 10'($urandom);
    make_random(60, line, lst);
    start_pass(lst, line);
    run_pass("overrun pass", 0, 1'b0, 10);
    check("overrun set", 64'(overrun), 64'(1));
    step();
    line = 10'($urandom);
    make_random(40, line, lst);
    start_pass(lst, line);
    run_pass("after overrun", 0, 1'b0, 0);
    check("overrun sticky", 64'(overrun), 64'(1));
    step();

    // Reset while slot 5 is being emitted
    for (int i = 0; i < N; i++)
      oam_mem[i] = {1'b1, 10'(i * 8), 10'(300 - i % 16), 8'(i), 3'(i % 8)};
    start_pass(full, 10'd300);
    spr_ready = 1'b1;
    found     = 0;
    for (int c = 0; c < 200 && found == 0; c++) begin
      if (spr_valid === 1'b1 && spr_slot === 5'd5) found = 1;
      else step();
    end
    check("rst emit5 reached", 64'(found), 64'(1));
    reset = 1'b1;
    step();
    check("rst mid spr_valid", 64'(spr_valid), 64'(0));
    check("rst mid busy", 64'(busy), 64'(0));
    check("rst mid line_done", 64'(line_done), 64'(0));
    check("rst mid overrun", 64'(overrun), 64'(0));
    reset     = 1'b0;
    spr_ready = 1'b0;
    quiet_bad = 0;
    for (int c = 0; c < 120; c++) begin
      if (line_done !== 1'b0 || spr_valid !== 1'b0 || busy !== 1'b0) quiet_bad++;
      step();
    end
    check("rst mid quiet", 64'(quiet_bad), 64'(0));
    start_pass(full, 10'd300);
    run_pass("full after reset", 0, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
